// File: rtl/my74ls191_pkg.sv
// Shared constants for the my74ls191 up/down counter.
// The DECADE_MODE_EN macro selects mod-10 digits (74LS190) instead of mod-16 (74LS191).
package my74ls191_pkg;

  localparam int          DIGIT_W  = 4;
  localparam logic [3:0]  HEX_MAX  = 4'hF;
  localparam logic [3:0]  DEC_MAX  = 4'h9;
  localparam logic        DIR_UP   = 1'b0;
  localparam logic        DIR_DOWN = 1'b1;

`ifdef DECADE_MODE_EN
  localparam bit          DECADE   = 1'b1;
`else
  localparam bit          DECADE   = 1'b0;
`endif

  localparam logic [3:0]  DIGIT_MAX = DECADE ? DEC_MAX : HEX_MAX;

endpackage

// File: rtl/my74ls191_if.sv
// Control/data bundle of the my74ls191 counter; CP and CR stay plain ports.
// The master drives controls and load data, the slave (the counter) drives state and flags.
interface my74ls191_if
  import my74ls191_pkg::*;
#(
  parameter int STAGES = 2
);

  localparam int W = DIGIT_W * STAGES;

  logic         LDn;
  logic [W-1:0] D;
  logic         CTEn;
  logic         DNUP;
  logic [W-1:0] Q;
  logic         MAX_MIN;
  logic         WRAP;

  modport master (
    output LDn, D, CTEn, DNUP,
    input  Q, MAX_MIN, WRAP
  );

  modport slave (
    input  LDn, D, CTEn, DNUP,
    output Q, MAX_MIN, WRAP
  );

endinterface

// File: rtl/my74ls191_digit.sv
// One 4-bit presettable up/down digit; its terminal-out feeds the next digit's enable.
// Digit maximum comes from the package (9 when DECADE_MODE_EN is defined, else F).
module my74ls191_digit
  import my74ls191_pkg::*;
(
  input  logic               CP,
  input  logic               CR,
  input  logic               LDn,
  input  logic [DIGIT_W-1:0] d,
  input  logic               en_in,
  input  logic               DNUP,
  output logic [DIGIT_W-1:0] q,
  output logic               tc_out
);

  // Up terminal uses >= so illegal BCD nibbles (A..F) roll to 0 with a carry.
  always_comb begin
    tc_out = 1'b0;
    if (DNUP == DIR_DOWN) tc_out = (q == '0);
    else                  tc_out = (q >= DIGIT_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so all digits update from pre-edge values.
  always_ff @(posedge CP) begin
    if (CR) begin
      q <= '0;
    end else if (!LDn) begin
      q <= d;
    end else if (en_in) begin
      if (DNUP == DIR_UP) q <= tc_out ? '0 : q + 4'd1;
      else                q <= tc_out ? DIGIT_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/my74ls191.sv
// Cascadable presettable up/down counter (74LS191, or 74LS190 with DECADE_MODE_EN).
// Digits ripple their enables combinationally; WRAP is a registered one-cycle pulse.
module my74ls191
  import my74ls191_pkg::*;
#(
  parameter int STAGES = 2
)(
  input  logic           CP,
  input  logic           CR,
  my74ls191_if.slave     bus
);

  localparam int W = DIGIT_W * STAGES;

  logic [STAGES-1:0] tc;
  logic [STAGES:0]   en;
  logic [W-1:0]      q;
  logic              wrap_q;

  // en[i] is high when counting is enabled and every lower digit is terminal.
  assign en[0] = ~bus.CTEn;

  for (genvar i = 0; i < STAGES; i++) begin : g_digit
    assign en[i+1] = en[i] & tc[i];

    my74ls191_digit u_digit (
      .CP     (CP),
      .CR     (CR),
      .LDn    (bus.LDn),
      .d      (bus.D[i*DIGIT_W +: DIGIT_W]),
      .en_in  (en[i]),
      .DNUP   (bus.DNUP),
      .q      (q[i*DIGIT_W +: DIGIT_W]),
      .tc_out (tc[i])
    );
  end

  // en[STAGES] means the top digit is rolling over on this edge.
  always_ff @(posedge CP) begin
    if (CR)            wrap_q <= 1'b0;
    else if (!bus.LDn) wrap_q <= 1'b0;
    else               wrap_q <= en[STAGES];
  end

  assign bus.Q       = q;
  assign bus.MAX_MIN = &tc;
  assign bus.WRAP    = wrap_q;

endmodule

// File: doc/my74ls191.md
# my74ls191

Synchronous, presettable, cascadable up/down counter in the 74LS19x style. It complements the team's up-only 74LS161 model: it adds a count-down direction with a borrow/minimum indication. Depending on the build, it runs either as a multi-nibble binary counter or as a 74LS190-style BCD (decade) counter. Intended users are the team's timer, divider and countdown datapaths that need count-down with terminal detection.

## Interface
Parameters:
- STAGES, default 2: number of cascaded 4-bit digits. Counter width W = 4*STAGES.

Ports:
- CP, input, 1: clock; all state changes on the rising edge.
- CR, input, 1: reset, synchronous, active-high.
- LDn, input, 1: parallel load, active-low, synchronous.
- D, input, W: parallel load data.
- CTEn, input, 1: count enable, active-low.
- DNUP, input, 1: direction; 0 = up, 1 = down.
- Q, output, W: counter state.
- MAX_MIN, output, 1: combinational terminal flag.
  - Up: high when every digit is at its maximum (F hex, or 9 in decade mode).
  - Down: high when Q = 0.
- WRAP, output, 1: registered one-cycle pulse following a cycle in which the counter wrapped.

## Operation
- Priority per edge is CR > load (LDn=0) > count (CTEn=0) > hold.
- CR=1: Q <= 0 and WRAP <= 0.
- LDn=0: Q <= D and WRAP <= 0. Load data is taken verbatim, including illegal BCD nibbles in decade mode.
- Count, up direction:
  - Digit 0 increments every enabled edge.
  - Digit i increments only when every lower digit is at its maximum.
  - A digit at its maximum goes to 0.
- Count, down direction:
  - Digit 0 decrements every enabled edge.
  - Digit i decrements only when every lower digit is 0.
  - A digit at 0 goes to its maximum.
- Decade mode boundaries:
  - Up from any value ≥9 goes to 0 and generates a carry.
  - Down from a value >9 decrements normally with no borrow.
- Wrap detection:
  - Up: Q = all-max and counting.
  - Down: Q = 0 and counting.
  - A wrap sets WRAP=1 for exactly the next cycle.
  - WRAP is 0 on every hold, load or reset edge.
- A DNUP change takes effect on the same edge. No state is kept about the previous direction.
- Reset values: Q = 0 and WRAP = 0. MAX_MIN equals DNUP after reset, because Q = 0.

## Timing
- Q latency is 1 cycle from the CP edge that samples the controls.
- MAX_MIN is purely combinational from Q and DNUP. It has zero-cycle response to a DNUP change.
- WRAP is registered. It is asserted in the cycle after the wrapping edge, coincident with Q showing the wrapped value.
- The digit enable chain is combinational within one cycle. There is no pipelining between stages.
- CR asserted during counting takes effect on the next edge, regardless of LDn and CTEn.

## Configuration
- DECADE_MODE_EN:
  - Defined: every digit counts mod-10 (digit maximum = 9), giving 74LS190 behaviour.
  - Undefined: every digit counts mod-16 (digit maximum = F), giving 74LS191 behaviour.
- The macro affects the digit maximum and MAX_MIN only. The interface is identical in both builds.

## Structure
- Package my74ls191_pkg holds:
  - DIGIT_W = 4
  - HEX_MAX = 4'hF
  - DEC_MAX = 4'h9
  - DIR_UP = 1'b0
  - DIR_DOWN = 1'b1
- Sub-module my74ls191_digit is one 4-bit stage instantiated STAGES times.
  - Inputs: CP, CR, LDn, D nibble, enable-in, DNUP.
  - Outputs: Q nibble and terminal-out (at max for up, at 0 for down).
- The top level ANDs the terminal-outs into each stage's enable chain, forms MAX_MIN, and registers WRAP.

## Test plan
- Reset: CR=1 with LDn=0, D=0x5A and CTEn=0 → Q=0x00, WRAP=0, MAX_MIN=DNUP.
- Hex up wrap (STAGES=2):
  - Load 0xFE, then up with CTEn=0 → Q goes 0xFF with MAX_MIN=1, then 0x00.
  - WRAP=1 only in the cycle Q=0x00.
- Hex down wrap: load 0x01, then down → Q goes 0x00 with MAX_MIN=1, then 0xFF with WRAP=1 in that cycle, then 0xFE with WRAP=0.
- Hold and priority:
  - CTEn=1 holds Q=0x37 for 5 cycles.
  - LDn=0 with CTEn=0 and D=0x12 → Q=0x12, no increment.
- Decade mode (DECADE_MODE_EN defined):
  - 0x19 up → 0x20.
  - 0x99 up → 0x00 with WRAP pulse.
  - 0x00 down → 0x99.
  - Loaded 0x0C up → 0x00 carry path, giving Q=0x10.
- Direction flip: at Q=0x80, toggle DNUP every cycle with CTEn=0 → Q sequence 0x81, 0x80, 0x81. MAX_MIN follows DNUP combinationally.
